// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive port demultiplexer.
package udp_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_DROP
   } udp_demux_state_t;

   typedef struct packed {
      logic [31:0] source_ip;
      logic [15:0] source_port;
      logic [15:0] dest_port;
      logic [15:0] length;
   } udp_hdr_t;

   localparam logic [31:0] UDP_BCAST_IP = 32'hFFFF_FFFF;

endpackage

// File: rtl/udp_port_match.sv
// Combinational priority matcher: lowest enabled channel whose port equals the destination port.
// With UDP_RX_IP_FILTER_EN defined, a failed destination-IP check suppresses the hit.
module udp_port_match #(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = 2
) (
   input  logic [NUM_CH*16-1:0] cfg_port,
   input  logic [NUM_CH-1:0]    cfg_enable,
   input  logic [15:0]          dest_port,
`ifdef UDP_RX_IP_FILTER_EN
   input  logic                 ip_ok,
`endif
   output logic                 hit,
   output logic [IDX_W-1:0]     idx
);

   always_comb begin
      hit = 1'b0;
      idx = '0;
      // Scan from the top so the lowest matching index is the last one written.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (cfg_enable[i] && (cfg_port[16*i +: 16] == dest_port)) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
`ifdef UDP_RX_IP_FILTER_EN
      if (!ip_ok) hit = 1'b0;
`endif
   end

endmodule

// File: rtl/udp_rx_port_demux.sv
// Routes UDP frames to NUM_CH consumers by dest port; unmatched frames are discarded and counted.
// Payload is a zero-latency pass-through; UDP_RX_IP_FILTER_EN adds a local/broadcast dest-IP check.
module udp_rx_port_demux
   import udp_rx_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic                 logic_clk,
   input  logic                 logic_rst,
   input  logic [NUM_CH*16-1:0] cfg_port,
   input  logic [NUM_CH-1:0]    cfg_enable,
   input  logic [31:0]          cfg_local_ip,
   input  logic                 s_udp_hdr_valid,
   output logic                 s_udp_hdr_ready,
   input  logic [31:0]          s_ip_source_ip,
   input  logic [31:0]          s_ip_dest_ip,
   input  logic [15:0]          s_udp_source_port,
   input  logic [15:0]          s_udp_dest_port,
   input  logic [15:0]          s_udp_length,
   input  logic [7:0]           s_udp_payload_axis_tdata,
   input  logic                 s_udp_payload_axis_tvalid,
   output logic                 s_udp_payload_axis_tready,
   input  logic                 s_udp_payload_axis_tlast,
   input  logic                 s_udp_payload_axis_tuser,
   output logic [NUM_CH-1:0]    m_udp_hdr_valid,
   input  logic [NUM_CH-1:0]    m_udp_hdr_ready,
   output logic [31:0]          m_ip_source_ip,
   output logic [15:0]          m_udp_source_port,
   output logic [15:0]          m_udp_dest_port,
   output logic [15:0]          m_udp_length,
   output logic [7:0]           m_udp_payload_axis_tdata,
   output logic                 m_udp_payload_axis_tlast,
   output logic                 m_udp_payload_axis_tuser,
   output logic [NUM_CH-1:0]    m_udp_payload_axis_tvalid,
   input  logic [NUM_CH-1:0]    m_udp_payload_axis_tready,
   output logic                 busy,
   output logic [CNT_W-1:0]     drop_count,
   output logic                 drop_pulse
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   udp_demux_state_t  state, state_next;
   udp_hdr_t          hdr;
   logic [IDX_W-1:0]  ch, hit_idx;
   logic [NUM_CH-1:0] ch_sel;
   logic              hit, hdr_hs;

`ifdef UDP_RX_IP_FILTER_EN
   logic ip_ok;
   assign ip_ok = (s_ip_dest_ip == cfg_local_ip) || (s_ip_dest_ip == UDP_BCAST_IP);
`else
   logic unused_ip;
   assign unused_ip = ^{cfg_local_ip, s_ip_dest_ip};
`endif

   udp_port_match #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_match (
      .cfg_port   (cfg_port),
      .cfg_enable (cfg_enable),
      .dest_port  (s_udp_dest_port),
`ifdef UDP_RX_IP_FILTER_EN
      .ip_ok      (ip_ok),
`endif
      .hit        (hit),
      .idx        (hit_idx)
   );

   assign hdr_hs = s_udp_hdr_valid && s_udp_hdr_ready;
   assign ch_sel = NUM_CH'(1) << ch;

   always_ff @(posedge logic_clk) begin
      if (logic_rst) state <= ST_IDLE;
      else           state <= state_next;
   end

   // Handshakes are gated by reset so nothing is accepted or offered while it is held.
   always_comb begin
      state_next                = state;
      s_udp_hdr_ready           = 1'b0;
      s_udp_payload_axis_tready = 1'b0;
      m_udp_hdr_valid           = '0;
      m_udp_payload_axis_tvalid = '0;
      busy                      = 1'b0;
      if (!logic_rst) begin
         case (state)
            ST_IDLE: begin
               s_udp_hdr_ready = 1'b1;
               if (s_udp_hdr_valid) state_next = hit ? ST_HDR : ST_DROP;
            end
            ST_HDR: begin
               busy            = 1'b1;
               m_udp_hdr_valid = ch_sel;
               if (|(m_udp_hdr_ready & ch_sel)) state_next = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               busy                      = 1'b1;
               m_udp_payload_axis_tvalid = s_udp_payload_axis_tvalid ? ch_sel : '0;
               s_udp_payload_axis_tready = |(m_udp_payload_axis_tready & ch_sel);
               if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tready && s_udp_payload_axis_tlast)
                  state_next = ST_IDLE;
            end
            ST_DROP: begin
               busy                      = 1'b1;
               s_udp_payload_axis_tready = 1'b1;
               if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge logic_clk) begin
      if (logic_rst) begin
         hdr        <= '0;
         ch         <= '0;
         drop_pulse <= 1'b0;
         drop_count <= '0;
      end else begin
         drop_pulse <= hdr_hs && !hit;
         if (hdr_hs) begin
            hdr <= '{source_ip:   s_ip_source_ip,
                     source_port: s_udp_source_port,
                     dest_port:   s_udp_dest_port,
                     length:      s_udp_length};
            ch  <= hit_idx;
            if (!hit && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
         end
      end
   end

   assign m_ip_source_ip           = hdr.source_ip;
   assign m_udp_source_port        = hdr.source_port;
   assign m_udp_dest_port          = hdr.dest_port;
   assign m_udp_length             = hdr.length;
   assign m_udp_payload_axis_tdata = s_udp_payload_axis_tdata;
   assign m_udp_payload_axis_tlast = s_udp_payload_axis_tlast;
   assign m_udp_payload_axis_tuser = s_udp_payload_axis_tuser;

endmodule

// File: tb/tb_udp_rx_port_demux.sv
// Directed + randomized bench for udp_rx_port_demux against a rule-level routing/drop model.
module tb_udp_rx_port_demux;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 4;
   localparam logic [31:0] LOCAL_IP = 32'h0A00_0002;

   logic                 logic_clk = 1'b0;
   logic                 logic_rst;
   logic [NUM_CH*16-1:0] cfg_port;
   logic [NUM_CH-1:0]    cfg_enable;
   logic [31:0]          cfg_local_ip;
   logic                 s_udp_hdr_valid, s_udp_hdr_ready;
   logic [31:0]          s_ip_source_ip, s_ip_dest_ip;
   logic [15:0]          s_udp_source_port, s_udp_dest_port, s_udp_length;
   logic [7:0]           s_udp_payload_axis_tdata;
   logic                 s_udp_payload_axis_tvalid, s_udp_payload_axis_tready;
   logic                 s_udp_payload_axis_tlast, s_udp_payload_axis_tuser;
   logic [NUM_CH-1:0]    m_udp_hdr_valid, m_udp_hdr_ready;
   logic [31:0]          m_ip_source_ip;
   logic [15:0]          m_udp_source_port, m_udp_dest_port, m_udp_length;
   logic [7:0]           m_udp_payload_axis_tdata;
   logic                 m_udp_payload_axis_tlast, m_udp_payload_axis_tuser;
   logic [NUM_CH-1:0]    m_udp_payload_axis_tvalid, m_udp_payload_axis_tready;
   logic                 busy, drop_pulse;
   logic [CNT_W-1:0]     drop_count;

   int n_cmp = 0;
   int n_mis = 0;
   int exp_drops = 0;
   int got_ch;

   always #5 logic_clk = ~logic_clk;

   udp_rx_port_demux #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .logic_clk(logic_clk), .logic_rst(logic_rst),
      .cfg_port(cfg_port), .cfg_enable(cfg_enable), .cfg_local_ip(cfg_local_ip),
      .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
      .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
      .s_udp_source_port(s_udp_source_port), .s_udp_dest_port(s_udp_dest_port),
      .s_udp_length(s_udp_length),
      .s_udp_payload_axis_tdata(s_udp_payload_axis_tdata),
      .s_udp_payload_axis_tvalid(s_udp_payload_axis_tvalid),
      .s_udp_payload_axis_tready(s_udp_payload_axis_tready),
      .s_udp_payload_axis_tlast(s_udp_payload_axis_tlast),
      .s_udp_payload_axis_tuser(s_udp_payload_axis_tuser),
      .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
      .m_ip_source_ip(m_ip_source_ip), .m_udp_source_port(m_udp_source_port),
      .m_udp_dest_port(m_udp_dest_port), .m_udp_length(m_udp_length),
      .m_udp_payload_axis_tdata(m_udp_payload_axis_tdata),
      .m_udp_payload_axis_tlast(m_udp_payload_axis_tlast),
      .m_udp_payload_axis_tuser(m_udp_payload_axis_tuser),
      .m_udp_payload_axis_tvalid(m_udp_payload_axis_tvalid),
      .m_udp_payload_axis_tready(m_udp_payload_axis_tready),
      .busy(busy), .drop_count(drop_count), .drop_pulse(drop_pulse)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Routing rule: lowest enabled channel with a matching port, else drop (-1).
   function automatic int model_ch(input logic [15:0] dport, input logic [31:0] dip);
`ifdef UDP_RX_IP_FILTER_EN
      if (dip != cfg_local_ip && dip != 32'hFFFF_FFFF) return -1;
`endif
      for (int i = 0; i < NUM_CH; i++)
         if (cfg_enable[i] && cfg_port[16*i +: 16] == dport && dip === dip) return i;
      return -1;
   endfunction

   task automatic check_quiet(input string tag);
      chk({tag, "_hdr_rdy"}, s_udp_hdr_ready, 0);
      chk({tag, "_pl_rdy"},  s_udp_payload_axis_tready, 0);
      chk({tag, "_m_hvld"},  m_udp_hdr_valid, 0);
      chk({tag, "_m_tvld"},  m_udp_payload_axis_tvalid, 0);
      chk({tag, "_busy"},    busy, 0);
      chk({tag, "_dpulse"},  drop_pulse, 0);
      chk({tag, "_dcount"},  drop_count, 0);
      chk({tag, "_hdr_regs"}, {m_ip_source_ip, m_udp_source_port, m_udp_dest_port}, 0);
      chk({tag, "_len_reg"}, m_udp_length, 0);
   endtask

   task automatic send_hdr(input logic [15:0] dport, input logic [31:0] dip, input int len,
                           output logic [31:0] sip, output logic [15:0] sport);
      int cyc = 0;
      bit hs = 0;
      sip = $urandom;
      sport = 16'($urandom);
      s_udp_payload_axis_tvalid = 1'b0;
      s_udp_hdr_valid = 1'b1;
      s_ip_source_ip = sip; s_ip_dest_ip = dip;
      s_udp_source_port = sport; s_udp_dest_port = dport; s_udp_length = 16'(len + 8);
      while (!hs && cyc < 20) begin
         @(negedge logic_clk);
         hs = s_udp_hdr_ready;
         @(posedge logic_clk); #1;
         cyc++;
      end
      chk("hdr_accept", hs, 1);
      s_udp_hdr_valid = 1'b0;
      s_ip_source_ip = $urandom; s_udp_source_port = 16'($urandom);
      s_udp_dest_port = 16'($urandom); s_udp_length = 16'($urandom);
   endtask

   task automatic run_frame(input logic [15:0] dport, input logic [31:0] dip, input int len,
                            input int stall_at, input int stall_len, input bit scramble,
                            output int obs_ch);
      logic [7:0] bytes[$];
      logic users[$];
      logic [31:0] sip;
      logic [15:0] sport;
      logic [NUM_CH*16-1:0] save_port = cfg_port;
      logic [NUM_CH-1:0] save_en = cfg_enable;
      logic [NUM_CH-1:0] onehot = '0;
      int exp = model_ch(dport, dip);
      int i = 0, cyc = 0, d;
      bit done = 0, stall, sel_rdy;
      for (int k = 0; k < len; k++) begin
         bytes.push_back(8'($urandom));
         users.push_back(1'($urandom));
      end
      if (exp >= 0) onehot[exp] = 1'b1;
      send_hdr(dport, dip, len, sip, sport);
      if (scramble) begin
         cfg_port = {$urandom, $urandom};
         cfg_enable = NUM_CH'($urandom);
      end
      obs_ch = -1;
      if (exp >= 0) begin
         d = $urandom_range(2);
         s_udp_payload_axis_tvalid = 1'b1;
         s_udp_payload_axis_tdata = bytes[0];
         s_udp_payload_axis_tlast = (len == 1);
         while (!done && cyc < 20) begin
            m_udp_hdr_ready = (NUM_CH'($urandom) & ~onehot) | ((cyc >= d) ? onehot : '0);
            @(negedge logic_clk);
            if (cyc == 0) begin
               for (int k = NUM_CH - 1; k >= 0; k--) if (m_udp_hdr_valid[k]) obs_ch = k;
               chk("fwd_dpulse", drop_pulse, 0);
               chk("m_src_ip", m_ip_source_ip, sip);
               chk("m_src_port", m_udp_source_port, sport);
               chk("m_dst_port", m_udp_dest_port, dport);
               chk("m_length", m_udp_length, 16'(len + 8));
            end
            chk("hdr_vld", m_udp_hdr_valid, onehot);
            chk("hdr_busy", busy, 1);
            chk("hdr_pl_stall", s_udp_payload_axis_tready, 0);
            chk("hdr_tvld", m_udp_payload_axis_tvalid, 0);
            done = (cyc >= d);
            @(posedge logic_clk); #1;
            cyc++;
         end
         m_udp_hdr_ready = NUM_CH'($urandom) & ~onehot;
         cyc = 0;
         while (i < len && cyc < 300) begin
            stall = (stall_len > 0) && cyc >= stall_at && cyc < stall_at + stall_len;
            sel_rdy = stall ? 1'b0 : ((stall_len > 0) ? 1'b1 : ($urandom_range(4) != 0));
            s_udp_payload_axis_tvalid = (stall_len > 0) ? 1'b1 : ($urandom_range(3) != 0);
            s_udp_payload_axis_tdata = bytes[i];
            s_udp_payload_axis_tuser = users[i];
            s_udp_payload_axis_tlast = (i == len - 1);
            m_udp_payload_axis_tready = (NUM_CH'($urandom) & ~onehot) | (sel_rdy ? onehot : '0);
            @(negedge logic_clk);
            chk("pl_tvld", m_udp_payload_axis_tvalid, s_udp_payload_axis_tvalid ? onehot : '0);
            chk("pl_tready", s_udp_payload_axis_tready, sel_rdy);
            chk("pl_hvld", m_udp_hdr_valid, 0);
            if (s_udp_payload_axis_tvalid && sel_rdy) begin
               chk("pl_tdata", m_udp_payload_axis_tdata, bytes[i]);
               chk("pl_tuser", m_udp_payload_axis_tuser, users[i]);
               chk("pl_tlast", m_udp_payload_axis_tlast, i == len - 1);
            end
            @(posedge logic_clk); #1;
            if (s_udp_payload_axis_tvalid && sel_rdy) i++;
            cyc++;
         end
      end else begin
         exp_drops = (exp_drops < (1 << CNT_W) - 1) ? exp_drops + 1 : exp_drops;
         while (i < len && cyc < 300) begin
            s_udp_payload_axis_tvalid = ($urandom_range(3) != 0);
            s_udp_payload_axis_tdata = bytes[i];
            s_udp_payload_axis_tlast = (i == len - 1);
            m_udp_payload_axis_tready = NUM_CH'($urandom);
            m_udp_hdr_ready = NUM_CH'($urandom);
            @(negedge logic_clk);
            chk("drop_dpulse", drop_pulse, cyc == 0);
            chk("drop_busy", busy, 1);
            chk("drop_tready", s_udp_payload_axis_tready, 1);
            chk("drop_hvld", m_udp_hdr_valid, 0);
            chk("drop_tvld", m_udp_payload_axis_tvalid, 0);
            @(posedge logic_clk); #1;
            if (s_udp_payload_axis_tvalid) i++;
            cyc++;
         end
      end
      chk("beats_done", i, len);
      s_udp_payload_axis_tvalid = 1'b0;
      s_udp_payload_axis_tlast = 1'b0;
      cfg_port = save_port;
      cfg_enable = save_en;
      @(negedge logic_clk);
      chk("end_busy", busy, 0);
      chk("end_hdr_rdy", s_udp_hdr_ready, 1);
      chk("end_dcount", drop_count, exp_drops);
      @(posedge logic_clk); #1;
   endtask

   initial begin
      logic [31:0] sip;
      logic [15:0] sport, dp;
      logic_rst = 1'b1;
      cfg_port = {16'd5003, 16'd5002, 16'd5001, 16'd5000};
      cfg_enable = '1;
      cfg_local_ip = LOCAL_IP;
      s_udp_hdr_valid = 0; s_ip_source_ip = 0; s_ip_dest_ip = 0;
      s_udp_source_port = 0; s_udp_dest_port = 0; s_udp_length = 0;
      s_udp_payload_axis_tdata = 0; s_udp_payload_axis_tvalid = 0;
      s_udp_payload_axis_tlast = 0; s_udp_payload_axis_tuser = 0;
      m_udp_hdr_ready = 0; m_udp_payload_axis_tready = 0;

      repeat (3) @(posedge logic_clk);
      #1;
      s_udp_hdr_valid = 1'b1;
      @(negedge logic_clk);
      check_quiet("rst");
      s_udp_hdr_valid = 1'b0;
      @(posedge logic_clk); #1;
      logic_rst = 1'b0;
      @(negedge logic_clk);
      chk("rel_hdr_rdy", s_udp_hdr_ready, 1);
      @(posedge logic_clk); #1;

      run_frame(16'd5002, LOCAL_IP, 10, 0, 0, 0, got_ch);
      chk("route_5002", got_ch, 2);
      run_frame(16'd6000, LOCAL_IP, 8, 0, 0, 0, got_ch);
      chk("route_6000", got_ch, -1);
      chk("drop_count_1", drop_count, 1);

      cfg_port[63:48] = 16'd5001;
      run_frame(16'd5001, LOCAL_IP, 5, 0, 0, 0, got_ch);
      chk("prio_low", got_ch, 1);
      cfg_enable[1] = 1'b0;
      run_frame(16'd5001, LOCAL_IP, 5, 0, 0, 0, got_ch);
      chk("prio_next", got_ch, 3);
      cfg_enable = '1;
      cfg_port = {16'd5003, 16'd5002, 16'd5001, 16'd5000};

      run_frame(16'd5000, LOCAL_IP, 12, 4, 5, 0, got_ch);
      chk("stall_route", got_ch, 0);
      run_frame(16'd5003, LOCAL_IP, 1, 0, 0, 0, got_ch);
      chk("single_beat", got_ch, 3);
      run_frame(16'd5001, LOCAL_IP, 6, 0, 0, 1, got_ch);
      chk("cfg_midframe", got_ch, 1);

      for (int n = 0; n < 30; n++) begin
         for (int j = 0; j < NUM_CH; j++) cfg_port[16*j +: 16] = 16'(5000 + $urandom_range(3));
         cfg_enable = NUM_CH'($urandom);
         dp = ($urandom_range(4) == 0) ? 16'($urandom) : 16'(5000 + $urandom_range(3));
         run_frame(dp, ($urandom_range(3) == 0) ? $urandom : LOCAL_IP,
                   $urandom_range(16, 1), 0, 0, 1'($urandom), got_ch);
      end
      cfg_enable = '1;
      cfg_port = {16'd5003, 16'd5002, 16'd5001, 16'd5000};

      // Reset while a frame is mid-payload.
      send_hdr(16'd5000, LOCAL_IP, 4, sip, sport);
      m_udp_hdr_ready = '1;
      @(posedge logic_clk); #1;
      s_udp_payload_axis_tvalid = 1'b1;
      m_udp_payload_axis_tready = '1;
      @(negedge logic_clk);
      chk("pre_rst_tready", s_udp_payload_axis_tready, 1);
      @(posedge logic_clk); #1;
      logic_rst = 1'b1;
      @(posedge logic_clk); #1;
      @(negedge logic_clk);
      check_quiet("midrst");
      @(posedge logic_clk); #1;
      logic_rst = 1'b0;
      s_udp_payload_axis_tvalid = 1'b0;
      m_udp_hdr_ready = '0;
      m_udp_payload_axis_tready = '0;
      exp_drops = 0;
      run_frame(16'd5001, LOCAL_IP, 3, 0, 0, 0, got_ch);
      chk("post_rst_route", got_ch, 1);

      for (int n = 0; n < (1 << CNT_W) + 2; n++)
         run_frame(16'd7000, LOCAL_IP, $urandom_range(3, 1), 0, 0, 0, got_ch);
      chk("drop_sat", drop_count, (1 << CNT_W) - 1);

`ifdef UDP_RX_IP_FILTER_EN
      run_frame(16'd5000, 32'h0A00_0003, 4, 0, 0, 0, got_ch);
      chk("ip_other", got_ch, -1);
      run_frame(16'd5000, 32'hFFFF_FFFF, 4, 0, 0, 0, got_ch);
      chk("ip_bcast", got_ch, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
